// File: rtl/demux_1_4.sv
// 1-to-4 demultiplexer: routes `in` onto the lane chosen by `sel` and zeroes the others.
// REG_OUT selects a one-cycle registered output (async active-low reset) or a purely combinational path.
module demux_1_4 #(
  parameter int DATA_W  = 1,
  parameter int REG_OUT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     in,
  input  logic [1:0]            sel,
  output logic [4*DATA_W-1:0]   y,
  output logic [3:0]            lane_act
);

  function automatic logic [3:0] decode_sel(input logic [1:0] s);
    logic [3:0] onehot;
    onehot = 4'b0000;
    case (s)
      2'd0:    onehot = 4'b0001;
      2'd1:    onehot = 4'b0010;
      2'd2:    onehot = 4'b0100;
      2'd3:    onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
    return onehot;
  endfunction

  // Lanes are gated by the one-hot decode, so at most one lane can ever be nonzero.
  function automatic logic [4*DATA_W-1:0] route_lanes(input logic [DATA_W-1:0] d,
                                                      input logic [3:0]        act);
    logic [4*DATA_W-1:0] lanes;
    lanes = '0;
    for (int k = 0; k < 4; k++) begin
      lanes[k*DATA_W +: DATA_W] = act[k] ? d : '0;
    end
    return lanes;
  endfunction

  logic [3:0]          w_lane_act_p0;
  logic [4*DATA_W-1:0] w_y_p0;

  // Stage p0: combinational decode and routing
  always_comb begin
    w_lane_act_p0 = decode_sel(sel);
    w_y_p0        = route_lanes(in, w_lane_act_p0);
  end

  generate
    if (REG_OUT != 0) begin : g_reg
      logic [3:0]          r_lane_act_p1;
      logic [4*DATA_W-1:0] r_y_p1;

      // Stage p1: output registers, cleared immediately on reset so no stale lane survives
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_lane_act_p1 <= 4'b0000;
          r_y_p1        <= '0;
        end else begin
          r_lane_act_p1 <= w_lane_act_p0;
          r_y_p1        <= w_y_p0;
        end
      end

      assign lane_act = r_lane_act_p1;
      assign y        = r_y_p1;
    end else begin : g_comb
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ rst_n;
      assign lane_act         = w_lane_act_p0;
      assign y                = w_y_p0;
    end
  endgenerate

endmodule

// File: tb/tb_demux_1_4.sv
// Bench for demux_1_4: registered DATA_W=1 instance plus a combinational DATA_W=8 instance,
// checked against a lane-arithmetic model every cycle and against hand-computed vectors.
module tb_demux_1_4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        in    = 1'b0;
  logic [1:0]  sel   = 2'd0;
  logic [3:0]  y;
  logic [3:0]  lane_act;

  logic [7:0]  in8  = 8'h00;
  logic [1:0]  sel8 = 2'd0;
  logic [31:0] y8;
  logic [3:0]  lane_act8;

  int checks = 0;
  int fails  = 0;

  // Model state: what the registered outputs must show
  logic [3:0] m_y   = 4'b0000;
  logic [3:0] m_act = 4'b0000;

  demux_1_4 #(.DATA_W(1), .REG_OUT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .sel(sel), .y(y), .lane_act(lane_act)
  );

  demux_1_4 #(.DATA_W(8), .REG_OUT(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .in(in8), .sel(sel8), .y(y8), .lane_act(lane_act8)
  );

  always #5 clk = ~clk;

  // Model: lane sel carries in, i.e. y = in * 2^sel; lane_act = 2^sel
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_y   = 4'b0000;
      m_act = 4'b0000;
    end else begin
      m_act = 4'(1 << int'(sel));
      m_y   = in ? m_act : 4'b0000;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, sampled on the falling edge
  always @(negedge clk) begin
    logic [31:0] e8;
    chk("model_y", {28'd0, y}, {28'd0, m_y});
    chk("model_lane_act", {28'd0, lane_act}, {28'd0, m_act});
    chk("one_lane_max", ($countones(y) <= 1) ? 32'd1 : 32'd0, 32'd1);
    e8 = 32'(in8) << (8 * int'(sel8));
    chk("comb8_model_y", y8, e8);
    chk("comb8_model_act", {28'd0, lane_act8}, 32'(1 << int'(sel8)));
  end

  // Drive in/sel at posedge+3, check registered result at the following posedge+2
  task automatic apply(input logic d, input logic [1:0] s,
                       input logic [3:0] ey, input logic [3:0] ea, input string name);
    in  = d;
    sel = s;
    @(posedge clk);
    #2;
    chk({name, "_y"}, {28'd0, y}, {28'd0, ey});
    chk({name, "_act"}, {28'd0, lane_act}, {28'd0, ea});
    #1;
  endtask

  initial begin
    // Reset asserted with in=1, sel=10: outputs must be zero at once
    rst_n = 1'b0;
    in    = 1'b1;
    sel   = 2'd2;
    in8   = 8'hA5;
    sel8  = 2'd2;
    #1;
    chk("rst_now_y", {28'd0, y}, 32'h0);
    chk("rst_now_act", {28'd0, lane_act}, 32'h0);
    chk("comb8_a5_sel2", y8, 32'h00A5_0000);
    chk("comb8_act_sel2", {28'd0, lane_act8}, 32'h4);

    repeat (2) @(posedge clk);
    #2;
    chk("rst_hold_y", {28'd0, y}, 32'h0);
    chk("rst_hold_act", {28'd0, lane_act}, 32'h0);
    #1;
    rst_n = 1'b1;

    // First edge after release loads the current in/sel; then each lane in turn
    apply(1'b1, 2'd0, 4'b0001, 4'b0001, "lane0");
    apply(1'b1, 2'd1, 4'b0010, 4'b0010, "lane1");
    apply(1'b1, 2'd2, 4'b0100, 4'b0100, "lane2");
    apply(1'b1, 2'd3, 4'b1000, 4'b1000, "lane3");

    // Zero data: lane_act still follows sel
    apply(1'b0, 2'd0, 4'b0000, 4'b0001, "zero0");
    apply(1'b0, 2'd1, 4'b0000, 4'b0010, "zero1");
    apply(1'b0, 2'd2, 4'b0000, 4'b0100, "zero2");
    apply(1'b0, 2'd3, 4'b0000, 4'b1000, "zero3");

    // Toggle in on lane 1
    apply(1'b1, 2'd1, 4'b0010, 4'b0010, "toggle_hi");
    apply(1'b0, 2'd1, 4'b0000, 4'b0010, "toggle_lo");

    // Async reset between edges while y=1000
    apply(1'b1, 2'd3, 4'b1000, 4'b1000, "pre_rst");
    #1;
    rst_n = 1'b0;
    #2;
    chk("midrst_y", {28'd0, y}, 32'h0);
    chk("midrst_act", {28'd0, lane_act}, 32'h0);
    @(posedge clk);
    #2;
    chk("midrst_hold_y", {28'd0, y}, 32'h0);
    #1;
    rst_n = 1'b1;
    apply(1'b1, 2'd0, 4'b0001, 4'b0001, "post_rst");
    apply(1'b1, 2'd2, 4'b0100, 4'b0100, "post_rst2");

    // Combinational instance: a few more lanes, no clock involvement needed
    in8  = 8'h3C;
    sel8 = 2'd3;
    #1;
    chk("comb8_3c_sel3", y8, 32'h3C00_0000);
    in8  = 8'hFF;
    sel8 = 2'd0;
    #1;
    chk("comb8_ff_sel0", y8, 32'h0000_00FF);

    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/demux_1_4.md
DEMUX_1_4 -- requirements
Module: demux_1_4

Interface
REQ-001 The parameter DATA_W SHALL default to 1 and set the width of each data lane in bits.
REQ-002 The parameter REG_OUT SHALL default to 1, where 1 gives a registered output and 0 gives a combinational output.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in  input  DATA_W  data to route.
REQ-006 sel  input  2  destination lane select, 0..3.
REQ-007 y  output  4*DATA_W  lane k SHALL occupy bits y[k*DATA_W +: DATA_W].
REQ-008 lane_act  output  4  one-hot lane indicator, aligned with y.

Function
REQ-009 Routing SHALL work as follows:
- lane sel SHALL carry in;
- the other three lanes SHALL be all-zero;
- for DATA_W=1: sel=00 -> y=000in, 01 -> 00in0, 10 -> 0in00, 11 -> in000.
REQ-010 lane_act SHALL be the one-hot decode of sel, bit sel=1, independent of the value of in.
REQ-011 With REG_OUT=1, y and lane_act SHALL reflect the in/sel sampled at the previous rising clk edge (latency 1 cycle, no bubbles, new value accepted every cycle).
REQ-012 With REG_OUT=0, y and lane_act SHALL follow in/sel combinationally (latency 0), and clk/rst_n SHALL have no effect.
REQ-013 When in=0 on the selected lane, y SHALL be all-zero while lane_act still indicates sel.
REQ-014 A simultaneous change of in and sel SHALL produce the new lane/value only, with no intermediate lane visible at the registered output.
REQ-015 If sel contains X/Z in simulation, the registered output SHALL be don't-care; the design SHALL NOT latch any state beyond the output registers.
REQ-016 The output SHALL never have more than one lane nonzero in any cycle.

Reset
REQ-017 With REG_OUT=1, asserting rst_n=0 SHALL clear y to 0 and lane_act to 0000 immediately, without waiting for a clock edge.
REQ-018 While rst_n=0, the outputs SHALL hold 0 regardless of in/sel.
REQ-019 After rst_n deasserts, the first rising clk edge SHALL load the current in/sel.
REQ-020 Reset asserted mid-stream SHALL discard the pending value; no stale lane SHALL reappear after release.

Verification
REQ-021 The bench (REG_OUT=1, DATA_W=1) SHALL cover these scenarios:
- Reset: rst_n=0 with in=1, sel=10 -> y=0000 and lane_act=0000 at once and throughout reset.
- Each lane: in=1 with sel=00/01/10/11 on consecutive cycles -> one cycle later y=0001/0010/0100/1000 and lane_act matches.
- Zero data: in=0, sel sweeping 00..11 -> y=0000 every cycle, with lane_act=0001/0010/0100/1000.
- Toggle: sel=01 held, in toggling 1,0 -> y=0010, 0000 each one cycle later.
- Async reset mid-stream: rst_n pulled low between edges while y=1000 -> y=0000 before the next edge; after release with in=1, sel=00 -> y=0001 on the first edge.
- DATA_W=8, REG_OUT=0: in=8'hA5, sel=10 -> y=32'h00A5_0000 with no clock needed.
